mmcm_drp_reconfig: RTL and testbench

MMCM_DRP_RECONFIG -- requirements
Module: mmcm_drp_reconfig

---
 rtl/mmcm_drp_reconfig_pkg.sv | 36 +++
 rtl/mmcm_drp_reconfig_sync.sv | 34 +++
 rtl/mmcm_drp_reconfig.sv | 187 ++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_drp_reconfig_pkg.sv
//------------------------------------------------------------------------------
// mmcm_drp_reconfig_pkg : shared widths, FSM states and the bit-merge helper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mmcm_drp_reconfig_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;
  localparam int TBL_IDX_W  = 5;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ASSERT_RST = 4'd1,
    ST_RD_REQ     = 4'd2,
    ST_RD_WAIT    = 4'd3,
    ST_WR_REQ     = 4'd4,
    ST_WR_WAIT    = 4'd5,
    ST_NEXT       = 4'd6,
    ST_RELEASE    = 4'd7,
    ST_WAIT_LOCK  = 4'd8
  } state_e;

  // Mask bit 1 keeps the value read back from the MMCM, 0 takes the table bit.
  function automatic logic [DRP_DATA_W-1:0] drp_merge(
    input logic [DRP_DATA_W-1:0] rd,
    input logic [DRP_DATA_W-1:0] mask,
    input logic [DRP_DATA_W-1:0] data
  );
    return (rd & mask) | (data & ~mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmcm_drp_reconfig_sync.sv
//------------------------------------------------------------------------------
// mmcm_drp_sync : reset-release synchroniser and 2-flop LOCKED synchroniser
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mmcm_drp_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic locked_i,
  output logic rst_n_sync_o,
  output logic locked_sync_o
);

  logic [1:0] rst_q;
  logic [1:0] lock_q;

  // Assertion is immediate, release lands on a clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_q  <= 2'b00;
      lock_q <= 2'b00;
    end else begin
      rst_q  <= {rst_q[0], 1'b1};
      lock_q <= {lock_q[0], locked_i};
    end
  end

  assign rst_n_sync_o  = rst_q[1];
  assign locked_sync_o = lock_q[1];

endmodule

`default_nettype wire

// File: rtl/mmcm_drp_reconfig.sv
//------------------------------------------------------------------------------
// mmcm_drp_reconfig : walks an external table doing DRP read-modify-writes
// while holding the MMCM in reset, then waits for lock.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mmcm_drp_reconfig
  import mmcm_drp_reconfig_pkg::*;
#(
  parameter int NUM_ENTRIES  = 23,
  parameter int DRDY_TIMEOUT = 63,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                  dclk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic [TBL_IDX_W-1:0]  tbl_idx_o,
  input  logic [DRP_ADDR_W-1:0] tbl_addr_i,
  input  logic [DRP_DATA_W-1:0] tbl_mask_i,
  input  logic [DRP_DATA_W-1:0] tbl_data_i,
  output logic [DRP_ADDR_W-1:0] daddr_o,
  output logic                  den_o,
  output logic                  dwe_o,
  output logic [DRP_DATA_W-1:0] di_o,
  input  logic [DRP_DATA_W-1:0] do_i,
  input  logic                  drdy_i,
  output logic                  mmcm_rst_o,
  input  logic                  locked_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int WD_W = $clog2(DRDY_TIMEOUT + 1);
  localparam int LK_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WD_W-1:0]      WD_LIM   = WD_W'(DRDY_TIMEOUT - 1);
  localparam logic [LK_W-1:0]      LK_LIM   = LK_W'(LOCK_TIMEOUT - 1);
  localparam logic [TBL_IDX_W-1:0] LAST_IDX = TBL_IDX_W'(NUM_ENTRIES - 1);

  logic rst_n_s;
  logic locked_s;

  mmcm_drp_sync u_sync (
    .clk_i         (dclk_i),
    .rst_n_i       (rst_n_i),
    .locked_i      (locked_i),
    .rst_n_sync_o  (rst_n_s),
    .locked_sync_o (locked_s)
  );

  state_e                 state_q,    state_d;
  logic [TBL_IDX_W-1:0]   idx_q,      idx_d;
  logic [DRP_ADDR_W-1:0]  daddr_q,    daddr_d;
  logic [DRP_DATA_W-1:0]  mask_q,     mask_d;
  logic [DRP_DATA_W-1:0]  data_q,     data_d;
  logic [DRP_DATA_W-1:0]  rdata_q,    rdata_d;
  logic [WD_W-1:0]        wd_cnt_q,   wd_cnt_d;
  logic [LK_W-1:0]        lk_cnt_q,   lk_cnt_d;
  logic                   mmcm_rst_q, mmcm_rst_d;
  logic                   err_q,      err_d;

  always_ff @(posedge dclk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      daddr_q    <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      wd_cnt_q   <= '0;
      lk_cnt_q   <= '0;
      mmcm_rst_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      daddr_q    <= daddr_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      wd_cnt_q   <= wd_cnt_d;
      lk_cnt_q   <= lk_cnt_d;
      mmcm_rst_q <= mmcm_rst_d;
      err_q      <= err_d;
    end
  end

  // The watchdog value counts the DEN cycle as cycle 1, so the limit test
  // fires in the DRDY_TIMEOUT-th cycle of the transaction.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    daddr_d    = daddr_q;
    mask_d     = mask_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    wd_cnt_d   = wd_cnt_q;
    lk_cnt_d   = lk_cnt_q;
    mmcm_rst_d = mmcm_rst_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_ASSERT_RST;
          idx_d      = '0;
          err_d      = 1'b0;
          mmcm_rst_d = 1'b1;
        end
      end
      ST_ASSERT_RST: state_d = ST_RD_REQ;
      ST_RD_REQ: begin
        daddr_d  = tbl_addr_i;
        mask_d   = tbl_mask_i;
        data_d   = tbl_data_i;
        wd_cnt_d = WD_W'(1);
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (drdy_i) begin
          rdata_d = do_i;
          state_d = ST_WR_REQ;
        end else if (wd_cnt_q >= WD_LIM) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          mmcm_rst_d = 1'b0;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      ST_WR_REQ: begin
        wd_cnt_d = WD_W'(1);
        state_d  = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (drdy_i) begin
          state_d = ST_NEXT;
        end else if (wd_cnt_q >= WD_LIM) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          mmcm_rst_d = 1'b0;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_RELEASE;
        end else begin
          idx_d   = idx_q + TBL_IDX_W'(1);
          state_d = ST_RD_REQ;
        end
      end
      ST_RELEASE: begin
        mmcm_rst_d = 1'b0;
        lk_cnt_d   = '0;
        state_d    = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_IDLE;
        end else if (lk_cnt_q >= LK_LIM) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          lk_cnt_d = lk_cnt_q + LK_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The read address is passed straight through so the table only has to be
  // valid in the cycle TBL_IDX points at it; afterwards the captured copy holds.
  assign den_o      = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign dwe_o      = (state_q == ST_WR_REQ);
  assign di_o       = dwe_o ? drp_merge(rdata_q, mask_q, data_q) : '0;
  assign daddr_o    = (state_q == ST_RD_REQ) ? tbl_addr_i : daddr_q;
  assign tbl_idx_o  = idx_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_WAIT_LOCK) && locked_s;
  assign mmcm_rst_o = mmcm_rst_q;
  assign err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mmcm_drp_reconfig.sv
//------------------------------------------------------------------------------
// tb_mmcm_drp_reconfig : scoreboard bench with a DRP responder and table ROM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mmcm_drp_reconfig;

  localparam int N       = 2;
  localparam int DRDY_TO = 63;
  localparam int LOCK_TO = 65535;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
  } txn_t;

  logic        dclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        locked = 1'b0;
  logic        drdy_r = 1'b0;
  logic        spur = 1'b0;
  logic [15:0] do_v = 16'h0;
  logic [4:0]  tbl_idx;
  logic [6:0]  tbl_addr, daddr;
  logic [15:0] tbl_mask, tbl_data, di;
  logic        den, dwe, mmcm_rst, busy, done, err;

  logic [6:0]  t_addr [32];
  logic [15:0] t_mask [32];
  logic [15:0] t_data [32];
  logic [15:0] rd_val [32];

  int   checks = 0, errors = 0, done_cnt = 0;
  int   rsp_lat = 3, hang_txn = 0, txn_no = 0, epoch = 0;
  bit   long_wr = 1'b0;
  txn_t exp_q[$];
  txn_t got;

  always #5 dclk = ~dclk;

  assign tbl_addr = t_addr[tbl_idx];
  assign tbl_mask = t_mask[tbl_idx];
  assign tbl_data = t_data[tbl_idx];

  mmcm_drp_reconfig #(
    .NUM_ENTRIES  (N),
    .DRDY_TIMEOUT (DRDY_TO),
    .LOCK_TIMEOUT (LOCK_TO)
  ) dut (
    .dclk_i     (dclk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .tbl_idx_o  (tbl_idx),
    .tbl_addr_i (tbl_addr),
    .tbl_mask_i (tbl_mask),
    .tbl_data_i (tbl_data),
    .daddr_o    (daddr),
    .den_o      (den),
    .dwe_o      (dwe),
    .di_o       (di),
    .do_i       (do_v),
    .drdy_i     (drdy_r | spur),
    .mmcm_rst_o (mmcm_rst),
    .locked_i   (locked),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DEN must match the next expected transaction.
  always @(negedge dclk) begin
    if (rst_n) begin
      if (den) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_den actual addr=0x%0h we=%0d required=no_transaction", daddr, dwe);
        end else begin
          got = exp_q.pop_front();
          chk("drp_txn", 32'({dwe, daddr, di}), 32'({got.we, got.addr, got.di}));
          chk("mmcm_rst_during_drp", 32'(mmcm_rst), 32'd1);
        end
      end else begin
        chk("idle_bus", 32'({dwe, di}), 32'd0);
      end
      if (done) done_cnt++;
    end
  end

  // DRP responder: DRDY after rsp_lat cycles; optionally never answers one txn.
  initial begin : responder
    bit         wr;
    int         ix, ep;
    logic [6:0] a;
    @(negedge dclk);
    forever begin
      if (rst_n && den) begin
        wr = dwe; ix = int'(tbl_idx); a = daddr; ep = epoch;
        txn_no++;
        if (txn_no == hang_txn) begin
          @(negedge dclk);
        end else begin
          repeat (rsp_lat) @(negedge dclk);
          if (ep == epoch && rst_n) begin
            chk("daddr_hold", 32'(daddr), 32'(a));
            drdy_r = 1'b1;
            do_v   = wr ? 16'($urandom) : rd_val[ix];
            @(negedge dclk);
            if (wr && long_wr) @(negedge dclk);
            drdy_r = 1'b0;
            do_v   = 16'h0;
          end
        end
      end else begin
        @(negedge dclk);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_den", 32'(den), 32'd0);
    chk("rst_dwe", 32'(dwe), 32'd0);
    chk("rst_di", 32'(di), 32'd0);
    chk("rst_daddr", 32'(daddr), 32'd0);
    chk("rst_tbl_idx", 32'(tbl_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
  endtask

  task automatic do_reset();
    start = 1'b0;
    locked = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    epoch++;
    repeat (3) @(negedge dclk);
    check_reset_vals();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge dclk);
  endtask

  // Reference model: each entry is a read then a merged write to the same address.
  task automatic push_model(input int upto);
    for (int i = 0; i < upto; i++) begin
      exp_q.push_back(txn_t'{we: 1'b0, addr: t_addr[i], di: 16'h0});
      exp_q.push_back(txn_t'{we: 1'b1, addr: t_addr[i],
                             di: (rd_val[i] & t_mask[i]) | (t_data[i] & ~t_mask[i])});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge dclk);
    start = 1'b0;
  endtask

  task automatic run_cfg(input bit noise, input int lock_delay);
    int n, d0;
    d0 = done_cnt;
    txn_no = 0;
    locked = 1'b0;
    push_model(N);
    pulse_start();
    n = 0;
    while (mmcm_rst && n < 5000) begin
      if (noise && $urandom_range(0, 7) == 0) pulse_start();
      else @(negedge dclk);
      n++;
    end
    chk("drp_phase_bound", 32'(n < 5000), 32'd1);
    chk("all_txn_issued", 32'(exp_q.size()), 32'd0);
    chk("busy_in_wait_lock", 32'(busy), 32'd1);
    repeat (lock_delay) @(negedge dclk);
    if (noise) pulse_start();
    locked = 1'b1;
    n = 0;
    do begin
      @(negedge dclk);
      n++;
    end while (!done && n < 10);
    chk("done_latency", 32'(n), 32'd2);
    @(negedge dclk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("err_after_done", 32'(err), 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin : main
    int n, d0;
    do_reset();

    // Spurious DRDY in IDLE must not start anything.
    spur = 1'b1;
    @(negedge dclk);
    spur = 1'b0;
    repeat (4) @(negedge dclk);
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_mmcm_rst", 32'(mmcm_rst), 32'd1);

    // Directed two-entry table, DO=0xFFFF -> writes 0x1041 then 0xFC00.
    t_addr[0] = 7'h08; t_mask[0] = 16'h1000; t_data[0] = 16'h0041; rd_val[0] = 16'hFFFF;
    t_addr[1] = 7'h09; t_mask[1] = 16'hFC00; t_data[1] = 16'h0000; rd_val[1] = 16'hFFFF;
    rsp_lat = 3; long_wr = 1'b0;
    run_cfg(1'b0, 3);

    // DRDY on the last permitted cycle still succeeds.
    rsp_lat = DRDY_TO - 1;
    run_cfg(1'b0, 1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        t_addr[i] = 7'($urandom);
        t_mask[i] = 16'($urandom);
        t_data[i] = 16'($urandom);
        rd_val[i] = 16'($urandom);
      end
      rsp_lat = $urandom_range(1, 6);
      long_wr = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_cfg(1'b1, $urandom_range(0, 5));
    end
    long_wr = 1'b0;

    // DRDY never returns on the first read.
    rsp_lat = 3; hang_txn = 1; txn_no = 0;
    exp_q.push_back(txn_t'{we: 1'b0, addr: t_addr[0], di: 16'h0});
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (!den && n < 20) begin
      @(negedge dclk);
      n++;
    end
    chk("first_den_seen", 32'(den), 32'd1);
    n = 0;
    do begin
      @(negedge dclk);
      n++;
    end while (!err && n < 200);
    chk("drdy_timeout_cycles", 32'(n), 32'(DRDY_TO));
    chk("drdy_to_mmcm_rst", 32'(mmcm_rst), 32'd0);
    chk("drdy_to_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge dclk);
    chk("drdy_to_no_done", 32'(done_cnt - d0), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);
    hang_txn = 0;

    // A new START clears ERR and completes normally.
    rsp_lat = 2;
    run_cfg(1'b0, 2);

    // Reset in the middle of entry 1's write wait.
    hang_txn = 4; txn_no = 0;
    push_model(N);
    pulse_start();
    n = 0;
    while (!(den && dwe && tbl_idx == 5'd1) && n < 500) begin
      @(negedge dclk);
      n++;
    end
    chk("entry1_write_seen", 32'(n < 500), 32'd1);
    repeat (4) @(negedge dclk);
    rst_n = 1'b0;
    epoch++;
    #1;
    check_reset_vals();
    chk("mid_reset_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    hang_txn = 0;
    @(negedge dclk);
    rst_n = 1'b1;
    repeat (3) @(negedge dclk);
    run_cfg(1'b0, 2);

    // LOCKED never rises after RELEASE.
    rsp_lat = 2; txn_no = 0; locked = 1'b0;
    push_model(N);
    pulse_start();
    n = 0;
    while (mmcm_rst && n < 2000) begin
      @(negedge dclk);
      n++;
    end
    chk("release_seen", 32'(n < 2000), 32'd1);
    n = 0;
    do begin
      @(negedge dclk);
      n++;
    end while (!err && n < 70000);
    chk("lock_timeout_cycles", 32'(n), 32'(LOCK_TO));
    chk("lock_to_busy", 32'(busy), 32'd0);
    chk("lock_to_mmcm_rst", 32'(mmcm_rst), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
